// File: rtl/irq_controller.sv
// irq_controller: rising-edge interrupt capture into a pending register,
// fixed lowest-index-wins priority among enabled sources, and a single
// request/acknowledge/return handshake with the core. No nesting.
module irq_controller #(
   parameter int          N_SRC      = 16,
   parameter logic [31:0] CAUSE_BASE = 32'h8000_0010,
   parameter int          ID_W       = $clog2(N_SRC)
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [N_SRC-1:0]  irq_src_i,
   input  logic [N_SRC-1:0]  irq_mask_i,
   input  logic              irq_ack_i,
   input  logic              irq_ret_i,
   output logic              irq_req_o,
   output logic [ID_W-1:0]   irq_id_o,
   output logic [31:0]       irq_cause_o,
   output logic [N_SRC-1:0]  irq_pend_o
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      SERVICE = 2'd2
   } state_t;

   state_t             state_reg, state_next;
   logic [N_SRC-1:0]   src_prev_reg;
   logic [N_SRC-1:0]   pending_reg, pending_next;
   logic [N_SRC-1:0]   edge_det;
   logic [N_SRC-1:0]   ack_clr;
   logic [N_SRC-1:0]   active;
   logic [ID_W-1:0]    id_reg, id_next;
   logic [ID_W-1:0]    winner;
   logic               req_reg, req_next;
   logic [31:0]        cause_reg, cause_next;

   // Per-source edge detect and pending update; a new edge beats the ack clear
   // so an interrupt arriving on the ack cycle is not lost.
   for (genvar gi = 0; gi < N_SRC; gi++) begin : g_src
      assign edge_det[gi]     = irq_src_i[gi] & ~src_prev_reg[gi];
      assign ack_clr[gi]      = (state_reg == REQ) && irq_ack_i && (id_reg == ID_W'(gi));
      assign pending_next[gi] = edge_det[gi] | (pending_reg[gi] & ~ack_clr[gi]);
   end

   assign active = pending_reg & irq_mask_i;

   // Fixed priority encoder: scanning downward leaves the lowest set index.
   always_comb begin
      winner = '0;
      for (int i = N_SRC - 1; i >= 0; i--) begin
         if (active[i]) begin
            winner = ID_W'(i);
         end
      end
   end

   // Next-state and next-output logic; id is only reloaded when leaving IDLE.
   always_comb begin
      state_next = state_reg;
      id_next    = id_reg;
      req_next   = 1'b0;
      case (state_reg)
         IDLE: begin
            if (|active) begin
               id_next    = winner;
               req_next   = 1'b1;
               state_next = REQ;
            end
         end
         REQ: begin
            req_next = 1'b1;
            if (irq_ack_i) begin
               req_next   = 1'b0;
               state_next = SERVICE;
            end
         end
         SERVICE: begin
            if (irq_ret_i) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
      cause_next = CAUSE_BASE + {{(32 - ID_W){1'b0}}, id_next};
   end

   // State, pending and output registers; reset drops any open transaction.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_reg    <= IDLE;
         src_prev_reg <= '0;
         pending_reg  <= '0;
         id_reg       <= '0;
         req_reg      <= 1'b0;
         cause_reg    <= CAUSE_BASE;
      end else begin
         state_reg    <= state_next;
         src_prev_reg <= irq_src_i;
         pending_reg  <= pending_next;
         id_reg       <= id_next;
         req_reg      <= req_next;
         cause_reg    <= cause_next;
      end
   end

   assign irq_req_o   = req_reg;
   assign irq_id_o    = id_reg;
   assign irq_cause_o = cause_reg;
   assign irq_pend_o  = pending_reg;

endmodule

// File: tb/tb_irq_controller.sv
// Testbench for irq_controller: expected served ids are queued when stimulus
// is driven and popped by a monitor each time irq_req_o rises.
module tb_irq_controller;

   localparam int          N_SRC      = 16;
   localparam int          ID_W       = 4;
   localparam logic [31:0] CAUSE_BASE = 32'h8000_0010;

   logic              clk;
   logic              rst_i;
   logic [N_SRC-1:0]  irq_src_i;
   logic [N_SRC-1:0]  irq_mask_i;
   logic              irq_ack_i;
   logic              irq_ret_i;
   logic              irq_req_o;
   logic [ID_W-1:0]   irq_id_o;
   logic [31:0]       irq_cause_o;
   logic [N_SRC-1:0]  irq_pend_o;

   int checks = 0;
   int errors = 0;
   int exp_q[$];
   logic req_prev = 1'b0;

   irq_controller #(
      .N_SRC      (N_SRC),
      .CAUSE_BASE (CAUSE_BASE)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst_i),
      .irq_src_i   (irq_src_i),
      .irq_mask_i  (irq_mask_i),
      .irq_ack_i   (irq_ack_i),
      .irq_ret_i   (irq_ret_i),
      .irq_req_o   (irq_req_o),
      .irq_id_o    (irq_id_o),
      .irq_cause_o (irq_cause_o),
      .irq_pend_o  (irq_pend_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Scoreboard monitor: every new request must match the oldest queued id.
   always @(negedge clk) begin
      if (irq_req_o === 1'b1 && req_prev !== 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected: got req id=%0d, required no request", irq_id_o);
         end else begin
            int e;
            e = exp_q.pop_front();
            if (irq_id_o !== ID_W'(e) || irq_cause_o !== CAUSE_BASE + 32'(e)) begin
               errors++;
               $display("FAIL sb_req: got id=%0d cause=%h, required id=%0d cause=%h",
                        irq_id_o, irq_cause_o, e, CAUSE_BASE + 32'(e));
            end else begin
               $display("req id=%0d cause=%h matched", irq_id_o, irq_cause_o);
            end
         end
      end
      req_prev = irq_req_o;
   end

   // Waits (bounded) for an asserted request, returning on that negedge.
   task automatic wait_req(input string name);
      bit seen = 1'b0;
      for (int n = 0; n < 50; n++) begin
         @(negedge clk);
         if (irq_req_o === 1'b1) begin
            seen = 1'b1;
            break;
         end
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL %s_timeout: got req=%b after 50 cycles, required 1", name, irq_req_o);
      end
   endtask

   // Acknowledge then return the current request.
   task automatic serve(input string name);
      wait_req(name);
      irq_ack_i = 1'b1;
      @(negedge clk);
      irq_ack_i = 1'b0;
      irq_ret_i = 1'b1;
      @(negedge clk);
      irq_ret_i = 1'b0;
   endtask

   task automatic test_reset();
      rst_i      = 1'b0;
      irq_src_i  = 16'hFFFF;
      irq_mask_i = 16'hFFFF;
      irq_ack_i  = 1'b0;
      irq_ret_i  = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (irq_req_o !== 1'b0 || irq_id_o !== 4'd0 || irq_cause_o !== CAUSE_BASE || irq_pend_o !== 16'h0) begin
         errors++;
         $display("FAIL reset_vals: got req=%b id=%0d cause=%h pend=%h, required 0 0 %h 0000",
                  irq_req_o, irq_id_o, irq_cause_o, irq_pend_o, CAUSE_BASE);
      end
      for (int k = 0; k < N_SRC; k++) exp_q.push_back(k);
      rst_i = 1'b1;
      @(negedge clk);
      checks++;
      if (irq_pend_o !== 16'hFFFF || irq_req_o !== 1'b0) begin
         errors++;
         $display("FAIL reset_release: got pend=%h req=%b, required ffff 0", irq_pend_o, irq_req_o);
      end
      @(negedge clk);
      checks++;
      if (irq_req_o !== 1'b1 || irq_id_o !== 4'd0) begin
         errors++;
         $display("FAIL reset_first_req: got req=%b id=%0d, required 1 0", irq_req_o, irq_id_o);
      end
      // Drain all sixteen in priority order.
      for (int k = 0; k < N_SRC; k++) begin
         if (k > 0) wait_req("reset_drain");
         irq_ack_i = 1'b1;
         @(negedge clk);
         irq_ack_i = 1'b0;
         checks++;
         if (irq_pend_o[k] !== 1'b0 || irq_req_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_drain_ack%0d: got pend=%h req=%b, required bit clear, req 0",
                     k, irq_pend_o, irq_req_o);
         end
         irq_ret_i = 1'b1;
         @(negedge clk);
         irq_ret_i = 1'b0;
      end
      irq_src_i = '0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_single();
      irq_mask_i = 16'h0010;
      exp_q.push_back(4);
      irq_src_i[4] = 1'b1;
      @(negedge clk);
      irq_src_i[4] = 1'b0;
      checks++;
      if (irq_pend_o !== 16'h0010 || irq_req_o !== 1'b0) begin
         errors++;
         $display("FAIL single_pend: got pend=%h req=%b, required 0010 0", irq_pend_o, irq_req_o);
      end
      @(negedge clk);
      checks++;
      if (irq_req_o !== 1'b1 || irq_id_o !== 4'd4 || irq_cause_o !== 32'h8000_0014) begin
         errors++;
         $display("FAIL single_req: got req=%b id=%0d cause=%h, required 1 4 80000014",
                  irq_req_o, irq_id_o, irq_cause_o);
      end
      irq_ack_i = 1'b1;
      @(negedge clk);
      irq_ack_i = 1'b0;
      checks++;
      if (irq_pend_o[4] !== 1'b0 || irq_req_o !== 1'b0 || irq_id_o !== 4'd4) begin
         errors++;
         $display("FAIL single_ack: got pend=%h req=%b id=%0d, required bit4 0, req 0, id 4",
                  irq_pend_o, irq_req_o, irq_id_o);
      end
      irq_ret_i = 1'b1;
      @(negedge clk);
      irq_ret_i = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (irq_req_o !== 1'b0 || irq_pend_o !== 16'h0) begin
         errors++;
         $display("FAIL single_idle: got req=%b pend=%h, required 0 0000", irq_req_o, irq_pend_o);
      end
   endtask

   task automatic test_priority();
      irq_mask_i = 16'hFFFF;
      exp_q.push_back(3);
      exp_q.push_back(9);
      irq_src_i[9] = 1'b1;
      irq_src_i[3] = 1'b1;
      @(negedge clk);
      irq_src_i = '0;
      serve("prio_first");
      checks++;
      if (irq_pend_o !== 16'h0200) begin
         errors++;
         $display("FAIL prio_left: got pend=%h, required 0200", irq_pend_o);
      end
      serve("prio_second");
      @(negedge clk);
   endtask

   task automatic test_masking();
      bit bad = 1'b0;
      irq_mask_i = 16'hFFDF;
      irq_src_i[5] = 1'b1;
      @(negedge clk);
      irq_src_i[5] = 1'b0;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         checks++;
         if (irq_req_o !== 1'b0 || irq_pend_o[5] !== 1'b1) begin
            errors++;
            $display("FAIL mask_hold%0d: got req=%b pend=%h, required 0 with bit5 set",
                     n, irq_req_o, irq_pend_o);
         end
      end
      exp_q.push_back(5);
      irq_mask_i = 16'hFFFF;
      @(negedge clk);
      checks++;
      if (irq_req_o !== 1'b1 || irq_id_o !== 4'd5) begin
         errors++;
         $display("FAIL mask_release: got req=%b id=%0d, required 1 5", irq_req_o, irq_id_o);
      end
      serve("mask_serve");
   endtask

   task automatic test_back_to_back();
      exp_q.push_back(2);
      irq_src_i[2] = 1'b1;
      @(negedge clk);
      irq_src_i[2] = 1'b0;
      wait_req("reedge_req");
      irq_ack_i    = 1'b1;
      irq_src_i[2] = 1'b1;
      @(negedge clk);
      irq_ack_i    = 1'b0;
      irq_src_i[2] = 1'b0;
      checks++;
      if (irq_pend_o[2] !== 1'b1 || irq_req_o !== 1'b0) begin
         errors++;
         $display("FAIL reedge_pend: got pend=%h req=%b, required bit2 set, req 0", irq_pend_o, irq_req_o);
      end
      exp_q.push_back(2);
      irq_ret_i = 1'b1;
      @(negedge clk);
      irq_ret_i = 1'b0;
      serve("reedge_again");
      checks++;
      if (irq_pend_o !== 16'h0) begin
         errors++;
         $display("FAIL reedge_clear: got pend=%h, required 0000", irq_pend_o);
      end
   endtask

   task automatic test_async_reset();
      exp_q.push_back(7);
      irq_src_i[7] = 1'b1;
      @(negedge clk);
      irq_src_i[7] = 1'b0;
      irq_src_i[6] = 1'b1;
      @(negedge clk);
      irq_src_i[6] = 1'b0;
      wait_req("areset_req");
      irq_ack_i = 1'b1;
      @(negedge clk);
      irq_ack_i = 1'b0;
      checks++;
      if (irq_req_o !== 1'b0 || irq_id_o !== 4'd7 || irq_pend_o !== 16'h0040) begin
         errors++;
         $display("FAIL areset_service: got req=%b id=%0d pend=%h, required 0 7 0040",
                  irq_req_o, irq_id_o, irq_pend_o);
      end
      #2;
      rst_i = 1'b0;
      #1;
      checks++;
      if (irq_req_o !== 1'b0 || irq_id_o !== 4'd0 || irq_cause_o !== CAUSE_BASE || irq_pend_o !== 16'h0) begin
         errors++;
         $display("FAIL areset_clear: got req=%b id=%0d cause=%h pend=%h, required 0 0 %h 0000",
                  irq_req_o, irq_id_o, irq_cause_o, irq_pend_o, CAUSE_BASE);
      end
      exp_q.delete();
      @(negedge clk);
      rst_i     = 1'b1;
      irq_ret_i = 1'b1;
      @(negedge clk);
      irq_ret_i = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (irq_req_o !== 1'b0 || irq_id_o !== 4'd0 || irq_pend_o !== 16'h0) begin
         errors++;
         $display("FAIL areset_stray_ret: got req=%b id=%0d pend=%h, required 0 0 0000",
                  irq_req_o, irq_id_o, irq_pend_o);
      end
      exp_q.push_back(1);
      irq_src_i[1] = 1'b1;
      @(negedge clk);
      irq_src_i[1] = 1'b0;
      serve("areset_after");
   endtask

   initial begin
      test_reset();
      test_single();
      test_priority();
      test_masking();
      test_back_to_back();
      test_async_reset();
      repeat (3) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL sb_leftover: got %0d unserved entries, required 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
